// File: rtl/sr_pkg.sv
// Shared definitions for the set/reset event interface.
//  - sr_state_e : 3-bit binary state encoding of the event generator FSM
//  - SR_IDLE / SR_TRIGGER : event line levels, shared with the downstream sr_fsm
//  - sr_is_stable() : true in the two resting states (LOW, HIGH)
package sr_pkg;

  typedef enum logic [2:0] {
    ST_LOW    = 3'd0,
    ST_QUAL_R = 3'd1,
    ST_SET_P  = 3'd2,
    ST_HOLD_H = 3'd3,
    ST_HIGH   = 3'd4,
    ST_QUAL_F = 3'd5,
    ST_CLR_P  = 3'd6,
    ST_HOLD_L = 3'd7
  } sr_state_e;

  localparam logic SR_IDLE    = 1'b0;
  localparam logic SR_TRIGGER = 1'b1;

  function automatic logic sr_is_stable(input sr_state_e s);
    return (s == ST_LOW) || (s == ST_HIGH);
  endfunction

endpackage

// File: rtl/sr_sync.sv
// Input synchroniser: STAGES-deep flop chain with synchronous active-high reset.
// STAGES=0 turns it into a wire (input already in the clk domain).
// Ports:
//  clk_i  in  clock, rising edge
//  rst_i  in  synchronous reset, clears the chain to 0
//  d_i    in  asynchronous level
//  q_o    out level delayed by STAGES flops
module sr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_chain
      logic [STAGES-1:0] sync_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= d_i;
          for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign q_o = sync_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/sr_event_gen.sv
// Transmit side of the set/reset event interface. Turns a level request into
// qualified one-shot set (E0) and clear (E1) pulses, filters glitches, holds
// off after every pulse and mirrors the downstream set/reset state.
// Ports:
//  clk          in   clock, all flops rising edge
//  rst          in   synchronous reset, active-high
//  lvl_in       in   requested level (1 = set, 0 = clear)
//  force_clr    in   single-cycle forced clear
//  E0           out  set pulse (registered)
//  E1           out  clear pulse (registered)
//  S_mirror     out  expected downstream state (registered)
//  busy         out  high outside the LOW/HIGH resting states
//  dbg_state_o  out  current FSM state
// Handshake: none; E0/E1 are fire-and-forget pulses, the receiver must accept
// one event per pulse and the GAP_CYC holdoff bounds the event rate.
module sr_event_gen
  import sr_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4,
  parameter int PULSE_W     = 1,
  parameter int GAP_CYC     = 2,
  parameter int CNT_W       = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      lvl_in,
  input  logic      force_clr,
  output logic      E0,
  output logic      E1,
  output logic      S_mirror,
  output logic      busy,
  output sr_state_e dbg_state_o
);

  localparam logic [CNT_W-1:0] FILT_T  = CNT_W'(FILT_CYC);
  localparam logic [CNT_W-1:0] PULSE_T = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] GAP_T   = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             lvl_s;
  sr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             e0_q, e0_d;
  logic             e1_q, e1_d;
  logic             s_mirror_q, s_mirror_d;

  sr_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (lvl_in),
    .q_o   (lvl_s)
  );

  always_comb begin
    state_d    = state_q;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    cnt_d      = cnt_q;
    e0_d       = SR_IDLE;
    e1_d       = SR_IDLE;
    s_mirror_d = s_mirror_q;

    case (state_q)
      ST_LOW:    if (lvl_s) state_d = ST_QUAL_R;
      ST_QUAL_R: begin
        if (!lvl_s)                state_d = ST_LOW;
        else if (cnt_q == FILT_T)  state_d = ST_SET_P;
      end
      ST_SET_P:  if (cnt_q == PULSE_T) state_d = (GAP_CYC == 0) ? ST_HIGH : ST_HOLD_H;
      ST_HOLD_H: if (cnt_q == GAP_T)   state_d = ST_HIGH;
      ST_HIGH:   if (!lvl_s) state_d = ST_QUAL_F;
      ST_QUAL_F: begin
        if (lvl_s)                 state_d = ST_HIGH;
        else if (cnt_q == FILT_T)  state_d = ST_CLR_P;
      end
      ST_CLR_P:  if (cnt_q == PULSE_T) state_d = (GAP_CYC == 0) ? ST_LOW : ST_HOLD_L;
      ST_HOLD_L: if (cnt_q == GAP_T)   state_d = ST_LOW;
      default:   state_d = ST_LOW;
    endcase

    // Forced clear overrides the normal transition; a clear already in
    // progress (CLR_P/HOLD_L) is left to finish.
    if (force_clr) begin
      case (state_q)
        ST_SET_P, ST_HOLD_H, ST_HIGH, ST_QUAL_F: state_d = ST_CLR_P;
        ST_LOW, ST_QUAL_R:                       state_d = ST_LOW;
        default: ;
      endcase
    end

    // One shared counter: counts in the timed states, reloads on entry
    // (0 for the resting states, 1 for everything else).
    if (!sr_is_stable(state_q)) cnt_d = cnt_inc;
    if (state_d != state_q) cnt_d = sr_is_stable(state_d) ? '0 : CNT_ONE;

    if (state_d == ST_SET_P) e0_d = SR_TRIGGER;
    if (state_d == ST_CLR_P) e1_d = SR_TRIGGER;

    // The downstream FSM changes state one cycle after it sees the event.
    if (e0_q)      s_mirror_d = 1'b1;
    else if (e1_q) s_mirror_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOW;
      cnt_q      <= '0;
      e0_q       <= SR_IDLE;
      e1_q       <= SR_IDLE;
      s_mirror_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      s_mirror_q <= s_mirror_d;
    end
  end

  assign E0          = e0_q;
  assign E1          = e1_q;
  assign S_mirror    = s_mirror_q;
  assign busy        = !sr_is_stable(state_q);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sr_event_gen.sv
module tb_sr_event_gen;
  import sr_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lvl_in = 1'b0;
  logic force_clr = 1'b0;

  always #5 clk = ~clk;

  // default-parameter DUT
  logic      e0, e1, s_m, bsy;
  sr_state_e st;
  // PULSE_W=3 DUT, same stimulus
  logic      e0_b, e1_b, s_m_b, bsy_b;
  sr_state_e st_b;

  int errors = 0;
  int checks = 0;

  sr_event_gen u_dut (
    .clk(clk), .rst(rst), .lvl_in(lvl_in), .force_clr(force_clr),
    .E0(e0), .E1(e1), .S_mirror(s_m), .busy(bsy), .dbg_state_o(st)
  );

  sr_event_gen #(.PULSE_W(3)) u_dut_pw3 (
    .clk(clk), .rst(rst), .lvl_in(lvl_in), .force_clr(force_clr),
    .E0(e0_b), .E1(e1_b), .S_mirror(s_m_b), .busy(bsy_b), .dbg_state_o(st_b)
  );

  // driver tasks: outputs are sampled 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; lvl_in = 1'b0; force_clr = 1'b0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  // rst held with lvl_in=1: everything quiet, then re-qualification after release
  task automatic test_reset();
    logic [7:0] exp8;
    logic [3:0] exp4;
    rst = 1'b1; lvl_in = 1'b1; force_clr = 1'b0;
    for (int e = 0; e < 3; e++) begin
      step();
      exp8 = 8'h00;
      checks++;
      if ({e0, e1, s_m, bsy, e0_b, e1_b, s_m_b, bsy_b} !== exp8) begin
        errors++;
        $display("FAIL reset_outs cyc=%0d got=%b exp=%b", e,
                 {e0, e1, s_m, bsy, e0_b, e1_b, s_m_b, bsy_b}, exp8);
      end
      checks++;
      if (st !== ST_LOW) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got=%0d exp=%0d", e, st, ST_LOW);
      end
    end
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      exp4 = {e == 6, 1'b0, e == 7, e >= 2};
      checks++;
      if ({e0, e1, s_m, bsy} !== exp4) begin
        errors++;
        $display("FAIL reset_requal e=%0d got=%b exp=%b", e, {e0, e1, s_m, bsy}, exp4);
      end
    end
  endtask

  // clean rising request held 20 cycles: one E0 after edge k+6
  task automatic test_set_pulse();
    logic [3:0] exp4;
    do_reset(2);
    lvl_in = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      exp4 = {e == 6, 1'b0, e >= 7, (e >= 2) && (e <= 8)};
      checks++;
      if ({e0, e1, s_m, bsy} !== exp4) begin
        errors++;
        $display("FAIL set_pulse e=%0d E0E1SB got=%b exp=%b", e, {e0, e1, s_m, bsy}, exp4);
      end
    end
    checks++;
    if (st !== ST_HIGH) begin
      errors++;
      $display("FAIL set_end_state got=%0d exp=%0d", st, ST_HIGH);
    end
  endtask

  // from HIGH, falling request held: one E1 after edge k+6
  task automatic test_clear_pulse();
    logic [3:0] exp4;
    lvl_in = 1'b0;
    for (int e = 0; e < 12; e++) begin
      step();
      exp4 = {1'b0, e == 6, e <= 6, (e >= 2) && (e <= 8)};
      checks++;
      if ({e0, e1, s_m, bsy} !== exp4) begin
        errors++;
        $display("FAIL clear_pulse e=%0d E0E1SB got=%b exp=%b", e, {e0, e1, s_m, bsy}, exp4);
      end
    end
    checks++;
    if (st !== ST_LOW) begin
      errors++;
      $display("FAIL clear_end_state got=%0d exp=%0d", st, ST_LOW);
    end
  endtask

  // 3-cycle glitch: busy while qualifying, no pulses
  task automatic test_glitch();
    logic [3:0] exp4;
    lvl_in = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step();
      if (e == 2) lvl_in = 1'b0;
      exp4 = {3'b000, (e >= 2) && (e <= 4)};
      checks++;
      if ({e0, e1, s_m, bsy} !== exp4) begin
        errors++;
        $display("FAIL glitch e=%0d E0E1SB got=%b exp=%b", e, {e0, e1, s_m, bsy}, exp4);
      end
    end
  endtask

  // force_clr in HIGH with lvl_in still 1
  task automatic test_force_clr_high();
    logic [3:0] exp4;
    do_reset(2);
    lvl_in = 1'b1;
    repeat (12) step();
    checks++;
    if ({st, s_m} !== {ST_HIGH, 1'b1}) begin
      errors++;
      $display("FAIL fclr_pre state/S got=%0d/%b exp=%0d/1", st, s_m, ST_HIGH);
    end
    force_clr = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step();
      if (e == 0) force_clr = 1'b0;
      exp4 = {e == 8, e == 0, (e == 0) || (e >= 9), !((e == 3) || (e == 11))};
      checks++;
      if ({e0, e1, s_m, bsy} !== exp4) begin
        errors++;
        $display("FAIL fclr_high e=%0d E0E1SB got=%b exp=%b", e, {e0, e1, s_m, bsy}, exp4);
      end
    end
  endtask

  // force_clr while qualifying a rise drops back to LOW, then re-qualifies
  task automatic test_force_clr_qual();
    sr_state_e exp_st;
    do_reset(2);
    lvl_in = 1'b1;
    for (int e = 0; e < 9; e++) begin
      step();
      if (e == 2) force_clr = 1'b1;
      if (e == 3) force_clr = 1'b0;
      if (e < 2)       exp_st = ST_LOW;
      else if (e == 2) exp_st = ST_QUAL_R;
      else if (e == 3) exp_st = ST_LOW;
      else if (e < 8)  exp_st = ST_QUAL_R;
      else             exp_st = ST_SET_P;
      checks++;
      if ({st, e0, e1} !== {exp_st, e == 8, 1'b0}) begin
        errors++;
        $display("FAIL fclr_qual e=%0d state/E0/E1 got=%0d/%b/%b exp=%0d/%b/0",
                 e, st, e0, e1, exp_st, e == 8);
      end
    end
  endtask

  // PULSE_W=3: rst during the second E0 cycle kills the pulse
  task automatic test_rst_mid_pulse();
    logic [1:0] exp2;
    do_reset(2);
    lvl_in = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      exp2 = {e >= 6, e >= 7};
      checks++;
      if ({e0_b, s_m_b} !== exp2) begin
        errors++;
        $display("FAIL pw3_pulse e=%0d E0/S got=%b exp=%b", e, {e0_b, s_m_b}, exp2);
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if ({e0_b, e1_b, s_m_b, bsy_b, st_b} !== {4'b0000, ST_LOW}) begin
      errors++;
      $display("FAIL pw3_rst got=%b/%0d exp=0000/%0d", {e0_b, e1_b, s_m_b, bsy_b}, st_b, ST_LOW);
    end
    rst = 1'b0;
    lvl_in = 1'b0;
    for (int e = 0; e < 5; e++) begin
      step();
      checks++;
      if ({e0_b, e1_b} !== 2'b00) begin
        errors++;
        $display("FAIL pw3_after e=%0d E0E1 got=%b exp=00", e, {e0_b, e1_b});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_set_pulse();
    test_clear_pulse();
    test_glitch();
    test_force_clr_high();
    test_force_clr_qual();
    test_rst_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
